// File: rtl/syzygy_adc_pkg.sv
// Shared types and constants for the SYZYGY ADC frame-alignment controller.
package syzygy_adc_pkg;

    typedef enum logic [2:0] {
        ST_SETTLE,
        ST_CHECK,
        ST_SLIP,
        ST_WAIT,
        ST_LOCKED,
        ST_FAIL
    } align_state_e;

    localparam logic [7:0] DEFAULT_FRAME_PATTERN = 8'hF0;

    // Counter width able to hold 0..limit, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/syzygy_adc_frame_align_if.sv
// Frame/data lane bus between the ISERDES capture stage and the alignment controller.
interface syzygy_adc_frame_align_if
    import syzygy_adc_pkg::*;
#(
    parameter int unsigned NUM_LANES = 4,
    parameter int unsigned MAX_SLIPS = 16
);
    localparam int unsigned SLIP_W = cnt_width(MAX_SLIPS);

    logic                     restart;
    logic [7:0]               frame_in;
    logic [8*NUM_LANES-1:0]   data_in;
    logic                     bitslip;
    logic                     locked;
    logic                     align_error;
    logic [SLIP_W-1:0]        slip_count;
    logic [8*NUM_LANES-1:0]   data_out;
    logic                     data_valid;

    modport master (
        output restart, frame_in, data_in,
        input  bitslip, locked, align_error, slip_count, data_out, data_valid
    );

    modport slave (
        input  restart, frame_in, data_in,
        output bitslip, locked, align_error, slip_count, data_out, data_valid
    );

endinterface

// File: rtl/syzygy_adc_match_counter.sv
// Saturating consecutive-event counter; reached flags the event that hits LIMIT.
module syzygy_adc_match_counter
    import syzygy_adc_pkg::*;
#(
    parameter int unsigned LIMIT = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic reached
);
    localparam int unsigned W = cnt_width(LIMIT);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc && (count_q != W'(LIMIT))) begin
            count_d = count_q + 1'b1;
        end
    end

    assign reached = inc && !clear && (count_q >= W'(LIMIT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/syzygy_adc_frame_align.sv
// Frame-lane bitslip alignment with lock/loss tracking and registered data-lane forwarding.
module syzygy_adc_frame_align
    import syzygy_adc_pkg::*;
#(
    parameter int unsigned NUM_LANES     = 4,
    parameter logic [7:0]  FRAME_PATTERN = DEFAULT_FRAME_PATTERN,
    parameter int unsigned SETTLE_CYCLES = 64,
    parameter int unsigned SLIP_WAIT     = 4,
    parameter int unsigned MATCH_COUNT   = 8,
    parameter int unsigned LOSS_COUNT    = 4,
    parameter int unsigned MAX_SLIPS     = 16
) (
    input  logic clk,
    input  logic reset,
    syzygy_adc_frame_align_if.slave bus
);
    localparam int unsigned TIMER_MAX = (SETTLE_CYCLES > SLIP_WAIT) ? SETTLE_CYCLES : SLIP_WAIT;
    localparam int unsigned TW        = cnt_width(TIMER_MAX);
    localparam int unsigned SW        = cnt_width(MAX_SLIPS);

    align_state_e           state_q, state_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic [SW-1:0]          slip_count_q, slip_count_d;
    logic                   bitslip_q, bitslip_d;
    logic                   locked_q, locked_d;
    logic                   align_error_q, align_error_d;
    logic                   data_valid_q, data_valid_d;
    logic [8*NUM_LANES-1:0] data_out_q, data_out_d;

    logic frame_match;
    logic match_reached;
    logic loss_reached;

    assign frame_match = (bus.frame_in == FRAME_PATTERN);

    // Matches only count in CHECK, so words seen during SLIP/WAIT never contribute.
    syzygy_adc_match_counter #(.LIMIT(MATCH_COUNT)) u_match_cnt (
        .clk     (clk),
        .reset   (reset),
        .clear   (bus.restart || (state_q != ST_CHECK)),
        .inc     ((state_q == ST_CHECK) && frame_match),
        .reached (match_reached)
    );

    syzygy_adc_match_counter #(.LIMIT(LOSS_COUNT)) u_loss_cnt (
        .clk     (clk),
        .reset   (reset),
        .clear   (bus.restart || (state_q != ST_LOCKED) || frame_match),
        .inc     ((state_q == ST_LOCKED) && !frame_match),
        .reached (loss_reached)
    );

    always_comb begin
        state_d      = state_q;
        timer_d      = '0;
        slip_count_d = slip_count_q;
        unique case (state_q)
            ST_SETTLE: begin
                if (timer_q == TW'(SETTLE_CYCLES - 1)) state_d = ST_CHECK;
                else                                   timer_d = timer_q + 1'b1;
            end
            ST_CHECK: begin
                if (match_reached) begin
                    state_d = ST_LOCKED;
                end else if (!frame_match) begin
                    if (slip_count_q == SW'(MAX_SLIPS)) begin
                        state_d = ST_FAIL;
                    end else begin
                        state_d      = ST_SLIP;
                        slip_count_d = slip_count_q + 1'b1;
                    end
                end
            end
            ST_SLIP:   state_d = ST_WAIT;
            ST_WAIT: begin
                if (timer_q == TW'(SLIP_WAIT - 1)) state_d = ST_CHECK;
                else                               timer_d = timer_q + 1'b1;
            end
            ST_LOCKED: begin
                // Losing lock starts a fresh attempt with its own slip budget.
                if (loss_reached) begin
                    state_d      = ST_CHECK;
                    slip_count_d = '0;
                end
            end
            ST_FAIL:   state_d = ST_FAIL;
            default:   state_d = ST_SETTLE;
        endcase

        if (bus.restart) begin
            state_d      = ST_SETTLE;
            timer_d      = '0;
            slip_count_d = '0;
        end

        // Outputs follow the next state so they are registered alongside it.
        bitslip_d     = (state_d == ST_SLIP);
        locked_d      = (state_d == ST_LOCKED);
        align_error_d = (state_d == ST_FAIL);
        data_valid_d  = (state_d == ST_LOCKED);
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            assign data_out_d[gi*8 +: 8] = bus.data_in[gi*8 +: 8];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_SETTLE;
            timer_q       <= '0;
            slip_count_q  <= '0;
            bitslip_q     <= 1'b0;
            locked_q      <= 1'b0;
            align_error_q <= 1'b0;
            data_valid_q  <= 1'b0;
            data_out_q    <= '0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            slip_count_q  <= slip_count_d;
            bitslip_q     <= bitslip_d;
            locked_q      <= locked_d;
            align_error_q <= align_error_d;
            data_valid_q  <= data_valid_d;
            data_out_q    <= data_out_d;
        end
    end

    assign bus.bitslip     = bitslip_q;
    assign bus.locked      = locked_q;
    assign bus.align_error = align_error_q;
    assign bus.slip_count  = slip_count_q;
    assign bus.data_out    = data_out_q;
    assign bus.data_valid  = data_valid_q;

endmodule

// File: doc/syzygy_adc_frame_align.md
Name: syzygy_adc_frame_align

Overview:
Frame-alignment controller in the SYZYGY ADC (LTC2264-12) capture path. Sits directly downstream of the DCO clocking stage and runs on its divided clock. It watches the deserialized FR (frame) lane word from the ISERDES and pulses a common bitslip until the frame word matches the expected pattern. It then holds lock, monitors for loss of lock, and forwards the aligned data-lane words with a valid flag.

Parameters:
NUM_LANES, 4, data lanes (2 channels x 2 lanes), each 8 bits per clk
FRAME_PATTERN, 8'hF0, expected frame-lane word when aligned
SETTLE_CYCLES, 64, wait after reset/restart before first check (MMCM/ISERDES settle)
SLIP_WAIT, 4, idle cycles after each bitslip pulse before checking resumes
MATCH_COUNT, 8, consecutive matches required to declare lock
LOSS_COUNT, 4, consecutive mismatches while locked that drop lock
MAX_SLIPS, 16, slips without lock before declaring failure

Ports:
clk  input  1  divided ADC clock (1/4 bit clock, from DCO MMCM)
reset  input  1  synchronous, active-high
restart  input  1  single-cycle pulse: re-run alignment from SETTLE
frame_in  input  8  deserialized frame-lane word
data_in  input  8*NUM_LANES  deserialized data-lane words, lane 0 in LSBs
bitslip  output  1  one-cycle pulse to all ISERDES bitslip inputs
locked  output  1  alignment achieved and held
align_error  output  1  MAX_SLIPS exhausted without lock
slip_count  output  $clog2(MAX_SLIPS+1)  slips issued in current attempt
data_out  output  8*NUM_LANES  registered data_in
data_valid  output  1  data_out captured while locked

Behaviour:
- Reset: all outputs 0, state SETTLE, all counters 0. Reset mid-operation aborts alignment the same way.
- SETTLE: count SETTLE_CYCLES cycles, then go to CHECK with the match counter at 0.
- CHECK: each cycle compare frame_in with FRAME_PATTERN.
  - Match: increment the match counter. When it reaches MATCH_COUNT, go to LOCKED and set locked=1 on the next cycle.
  - Mismatch: if slip_count == MAX_SLIPS, go to FAIL. Otherwise go to SLIP.
- SLIP: assert bitslip for exactly one cycle, increment slip_count (saturates at MAX_SLIPS), clear the match counter, then go to WAIT.
- WAIT: SLIP_WAIT cycles with bitslip=0 and frame_in ignored, then CHECK.
- Bitslip pulses are therefore spaced at least SLIP_WAIT+2 cycles apart.
- LOCKED: count consecutive mismatches; any match clears the count.
  - When the count reaches LOSS_COUNT: locked=0, clear slip_count, go to CHECK. The next mismatch in CHECK slips.
- FAIL: align_error=1, locked=0, no bitslip. Held until restart or reset.
- restart (any state): next state SETTLE; locked, align_error, slip_count and counters all cleared. reset has priority over restart.
- If a mismatch drops lock in the same cycle restart asserts, restart wins.
- Data path: data_out <= data_in every cycle (1-cycle latency). data_valid <= (state==LOCKED), so data_valid tracks locked. Data is not gated to 0; consumers use data_valid.
- A frame word captured during WAIT never contributes to a match.

Decomposition:
- Package syzygy_adc_pkg: align-state encoding (SETTLE, CHECK, SLIP, WAIT, LOCKED, FAIL) and the default FRAME_PATTERN constant.
- One sub-module is natural: syzygy_adc_match_counter, a parameterised saturating consecutive-event counter with clear. Instantiate it twice, for matches (CHECK) and for mismatches (LOCKED).

Test Plan:
- frame_in is FRAME_PATTERN rotated by 3 and rotates one position per bitslip → exactly 3 bitslip pulses after the 64-cycle settle, each 1 cycle wide and ≥6 cycles apart. locked=1 after 8 matches, slip_count=3, data_valid follows.
- frame_in stuck at 8'h00 → 16 slips, then align_error=1, locked=0, no further bitslip. A restart pulse then clears align_error and slip_count, and SETTLE reruns.
- Locked, then 3 mismatches then a match → locked stays 1. Then 4 consecutive mismatches → locked=0 on the 4th and realignment begins, with slip_count restarting at 0.
- Reset asserted during WAIT after 2 slips → next cycle all outputs 0, state SETTLE. Full alignment then completes normally.
- Mismatching frame words presented only during WAIT, correct words otherwise → no extra slips caused.
- data_in incrementing every cycle → data_out equals the previous cycle's data_in in every state. data_valid=1 only while locked=1.
